// File: rtl/rpn_eval_stack_if.sv
// Token/result bus between the token parser, the RPN evaluator and result logic.
// master = token source (drives strobes and CLR), slave = evaluator.
// Widths follow DATA_W and DEPTH of the attached evaluator.
interface rpn_eval_stack_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] NUM_IN;
  logic              NUM_STB;
  logic [7:0]        OP_IN;
  logic              OP_STB;
  logic              END_STB;
  logic              CLR;
  logic              BUSY;
  logic [DATA_W-1:0] RESULT;
  logic              RESULT_VLD;
  logic              ERR;
  logic [2:0]        ERR_CODE;
  logic [PTR_W:0]    DEPTH_OUT;

  modport master (
    output NUM_IN, NUM_STB, OP_IN, OP_STB, END_STB, CLR,
    input  BUSY, RESULT, RESULT_VLD, ERR, ERR_CODE, DEPTH_OUT
  );

  modport slave (
    input  NUM_IN, NUM_STB, OP_IN, OP_STB, END_STB, CLR,
    output BUSY, RESULT, RESULT_VLD, ERR, ERR_CODE, DEPTH_OUT
  );
endinterface

// File: rtl/rpn_eval_stack.sv
// Postfix evaluator: pushes numbers, runs unsigned ALU ops on the top two entries.
// Latency: push 1 cycle; operator 3 cycles (BUSY high 2); END 1 cycle.
// Backpressure: strobes honoured only in IDLE with BUSY=0, ignored otherwise; errors stick until CLR/RST.
module rpn_eval_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input logic          CLK,
  input logic          RST,
  rpn_eval_stack_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] TWO  = (PTR_W+1)'(2);

  localparam logic [2:0] E_NONE = 3'd0, E_OVF = 3'd1, E_UNF = 3'd2, E_DIV0 = 3'd3,
                         E_BAD_OP = 3'd4, E_BAD_END = 3'd5, E_COLL = 3'd6;

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERROR} state_t;

  state_t            state, state_nxt;
  logic [2:0]        code_nxt;
  logic [PTR_W:0]    sp;
  logic [PTR_W:0]    sp_m1, sp_m2;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] opa, opb, alu, alu_q;
  logic [7:0]        op;
  logic              do_push, do_latch, do_end, do_wb;
  logic              collide, op_ok, div0;

  logic              busy_q, err_q, vld_q;
  logic [2:0]        code_q;
  logic [DATA_W-1:0] result_q;

  assign sp_m1   = sp - ONE;
  assign sp_m2   = sp - TWO;
  assign collide = (bus.NUM_STB & bus.OP_STB) | (bus.NUM_STB & bus.END_STB) |
                   (bus.OP_STB & bus.END_STB);
  assign op_ok   = bus.OP_IN inside {"+", "-", "*", "/", "%", "&", "|", "^"};
  assign div0    = ((op == "/") || (op == "%")) && (opb == '0);

  // Unsigned ALU on the latched operands; A is the earlier-pushed value.
  always_comb begin
    alu = '0;
    case (op)
      "+":     alu = opa + opb;
      "-":     alu = opa - opb;
      "*":     alu = opa * opb;
      "/":     if (opb != '0) alu = opa / opb;
      "%":     if (opb != '0) alu = opa % opb;
      "&":     alu = opa & opb;
      "|":     alu = opa | opb;
      "^":     alu = opa ^ opb;
      default: alu = '0;
    endcase
  end

  // Next-state and per-cycle actions; CLR overrides every strobe in every state.
  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    do_push   = 1'b0;
    do_latch  = 1'b0;
    do_end    = 1'b0;
    do_wb     = 1'b0;
    if (bus.CLR) begin
      state_nxt = IDLE;
      code_nxt  = E_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (collide) begin
            state_nxt = ERROR;
            code_nxt  = E_COLL;
          end else if (bus.NUM_STB) begin
            if (sp == FULL) begin
              state_nxt = ERROR;
              code_nxt  = E_OVF;
            end else begin
              do_push = 1'b1;
            end
          end else if (bus.OP_STB) begin
            if (sp < TWO) begin
              state_nxt = ERROR;
              code_nxt  = E_UNF;
            end else if (!op_ok) begin
              state_nxt = ERROR;
              code_nxt  = E_BAD_OP;
            end else begin
              do_latch  = 1'b1;
              state_nxt = EXEC;
            end
          end else if (bus.END_STB) begin
            if (sp == ONE) begin
              do_end = 1'b1;
            end else begin
              state_nxt = ERROR;
              code_nxt  = E_BAD_END;
            end
          end
        end
        EXEC: begin
          if (div0) begin
            state_nxt = ERROR;
            code_nxt  = E_DIV0;
          end else begin
            state_nxt = WB;
          end
        end
        WB: begin
          do_wb     = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = ERROR;
      endcase
    end
  end

  // Control state, stack pointer, operand latches and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      sp       <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= E_NONE;
      vld_q    <= 1'b0;
      result_q <= '0;
      opa      <= '0;
      opb      <= '0;
      op       <= '0;
      alu_q    <= '0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      busy_q <= (state_nxt != IDLE);
      err_q  <= (state_nxt == ERROR);
      vld_q  <= do_end;
      if (bus.CLR)     sp <= '0;
      else if (do_push) sp <= sp + ONE;
      else if (do_end)  sp <= '0;
      else if (do_wb)   sp <= sp_m1;
      if (do_latch) begin
        opb <= mem[sp_m1[PTR_W-1:0]];
        opa <= mem[sp_m2[PTR_W-1:0]];
        op  <= bus.OP_IN;
      end
      if (state == EXEC) alu_q <= alu;
      if (do_end) result_q <= mem[0];
    end
  end

  // Stack storage is deliberately left unreset; occupancy is tracked by sp alone.
  always_ff @(posedge CLK) begin
    if (do_push)    mem[sp[PTR_W-1:0]]    <= bus.NUM_IN;
    else if (do_wb) mem[sp_m2[PTR_W-1:0]] <= alu_q;
  end

  assign bus.BUSY       = busy_q;
  assign bus.ERR        = err_q;
  assign bus.ERR_CODE   = code_q;
  assign bus.RESULT_VLD = vld_q;
  assign bus.RESULT     = result_q;
  assign bus.DEPTH_OUT  = sp;
endmodule

// File: tb/tb_rpn_eval_stack.sv
// Directed bench for rpn_eval_stack at DATA_W=8, DEPTH=4.
// Table of two-operand expressions plus hand sequences for busy timing, overflow, errors and async reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_rpn_eval_stack;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rpn_eval_stack_if #(.DATA_W(8), .DEPTH(4)) bus ();

  rpn_eval_stack #(.DATA_W(8), .DEPTH(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
    logic [2:0] code;
  } vec_t;

  typedef struct {
    bit         is_op;
    logic [7:0] v;
  } tok_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    bus.NUM_IN  = v;
    bus.NUM_STB = 1'b1;
    step();
    bus.NUM_STB = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] c);
    bus.OP_IN  = c;
    bus.OP_STB = 1'b1;
    step();
    bus.OP_STB = 1'b0;
  endtask

  task automatic end_tok(output logic vld);
    bus.END_STB = 1'b1;
    step();
    bus.END_STB = 1'b0;
    vld = bus.RESULT_VLD;
  endtask

  task automatic do_clr();
    bus.CLR = 1'b1;
    step();
    bus.CLR = 1'b0;
  endtask

  // Waits for the evaluator to return to IDLE or land in ERROR, bounded.
  task automatic settle();
    int n = 0;
    while (bus.BUSY && !bus.ERR && n < 8) begin
      step();
      n++;
    end
    if (n >= 8) begin
      checks++;
      errors++;
      $display("FAIL settle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  vec_t vecs[10];
  tok_t toks[9];

  initial begin
    logic vld;
    int   busy_cycles;
    int   peak;
    logic err_seen;

    bus.NUM_IN = '0; bus.NUM_STB = 0; bus.OP_IN = '0; bus.OP_STB = 0;
    bus.END_STB = 0; bus.CLR = 0;

    vecs[0] = '{8'd3,   8'd4,  "+", 8'd7,   3'd0};
    vecs[1] = '{8'd2,   8'd5,  "-", 8'd253, 3'd0};
    vecs[2] = '{8'd7,   8'd2,  "%", 8'd1,   3'd0};
    vecs[3] = '{8'd100, 8'd7,  "/", 8'd14,  3'd0};
    vecs[4] = '{8'd12,  8'd10, "&", 8'd8,   3'd0};
    vecs[5] = '{8'd12,  8'd10, "|", 8'd14,  3'd0};
    vecs[6] = '{8'd12,  8'd10, "^", 8'd6,   3'd0};
    vecs[7] = '{8'd9,   8'd0,  "%", 8'd0,   3'd3};
    vecs[8] = '{8'd1,   8'd2,  "a", 8'd0,   3'd4};
    vecs[9] = '{8'd200, 8'd2,  "*", 8'd144, 3'd0};

    toks[0] = '{0, 8'd5}; toks[1] = '{0, 8'd1}; toks[2] = '{0, 8'd2};
    toks[3] = '{1, "+"};  toks[4] = '{0, 8'd4}; toks[5] = '{1, "*"};
    toks[6] = '{1, "+"};  toks[7] = '{0, 8'd3}; toks[8] = '{1, "-"};

    // Reset values before any clock edge.
    #2;
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_result", bus.RESULT, 0);
    chk("rst_vld", bus.RESULT_VLD, 0);
    chk("rst_err", bus.ERR, 0);
    chk("rst_code", bus.ERR_CODE, 0);
    chk("rst_depth", bus.DEPTH_OUT, 0);
    #10 RST = 1'b0;
    step();

    // 3 4 + END with BUSY timing.
    push(8'd3);
    push(8'd4);
    chk("push_busy", bus.BUSY, 0);
    chk("push_depth", bus.DEPTH_OUT, 2);
    do_op("+");
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.BUSY) busy_cycles++;
      step();
    end
    chk("op_busy_cycles", busy_cycles, 2);
    chk("op_depth", bus.DEPTH_OUT, 1);
    end_tok(vld);
    chk("add_vld", vld, 1);
    chk("add_result", bus.RESULT, 7);
    chk("add_depth", bus.DEPTH_OUT, 0);
    step();
    chk("vld_pulse", bus.RESULT_VLD, 0);

    // 5 1 2 + 4 * + 3 - END.
    peak = 0;
    err_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (toks[i].is_op) begin
        do_op(toks[i].v);
        settle();
      end else begin
        push(toks[i].v);
      end
      if (int'(bus.DEPTH_OUT) > peak) peak = int'(bus.DEPTH_OUT);
      err_seen |= bus.ERR;
    end
    end_tok(vld);
    chk("stream_result", bus.RESULT, 14);
    chk("stream_peak", peak, 3);
    chk("stream_err", err_seen, 0);

    // Two-operand expression table.
    for (int i = 0; i < 10; i++) begin
      do_clr();
      push(vecs[i].a);
      push(vecs[i].b);
      do_op(vecs[i].op);
      settle();
      if (vecs[i].code == 3'd0) begin
        end_tok(vld);
        chk($sformatf("vec%0d_result", i), bus.RESULT, vecs[i].res);
        chk($sformatf("vec%0d_vld", i), vld, 1);
      end else begin
        chk($sformatf("vec%0d_code", i), bus.ERR_CODE, vecs[i].code);
        chk($sformatf("vec%0d_depth", i), bus.DEPTH_OUT, 2);
      end
    end

    // 7 0 / -> divide by zero; later pushes ignored; CLR keeps RESULT.
    do_clr();
    push(8'd7);
    push(8'd0);
    do_op("/");
    step();
    chk("div0_err", bus.ERR, 1);
    chk("div0_code", bus.ERR_CODE, 3);
    chk("div0_depth", bus.DEPTH_OUT, 2);
    chk("div0_busy", bus.BUSY, 1);
    push(8'd9);
    chk("div0_ignore_push", bus.DEPTH_OUT, 2);
    do_clr();
    chk("clr_err", bus.ERR, 0);
    chk("clr_code", bus.ERR_CODE, 0);
    chk("clr_depth", bus.DEPTH_OUT, 0);
    chk("clr_busy", bus.BUSY, 0);
    chk("clr_result", bus.RESULT, 144);

    // Five back-to-back pushes into a 4-deep stack.
    bus.NUM_STB = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.NUM_IN = 8'(i + 1);
      step();
    end
    bus.NUM_STB = 1'b0;
    chk("ovf_code", bus.ERR_CODE, 1);
    chk("ovf_depth", bus.DEPTH_OUT, 4);

    // Underflow.
    do_clr();
    push(8'd1);
    do_op("+");
    chk("unf_code", bus.ERR_CODE, 2);
    chk("unf_depth", bus.DEPTH_OUT, 1);

    // Strobe collision.
    do_clr();
    bus.NUM_STB = 1'b1;
    bus.OP_STB  = 1'b1;
    step();
    bus.NUM_STB = 1'b0;
    bus.OP_STB  = 1'b0;
    chk("coll_code", bus.ERR_CODE, 6);
    chk("coll_depth", bus.DEPTH_OUT, 0);

    // END with depth 2, and END with empty stack.
    do_clr();
    push(8'd1);
    push(8'd2);
    end_tok(vld);
    chk("end2_code", bus.ERR_CODE, 5);
    chk("end2_vld", vld, 0);
    chk("end2_result", bus.RESULT, 144);
    do_clr();
    end_tok(vld);
    chk("end0_code", bus.ERR_CODE, 5);

    // Async reset while a '*' sits in EXEC.
    do_clr();
    push(8'd6);
    push(8'd7);
    do_op("*");
    chk("exec_busy", bus.BUSY, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", bus.BUSY, 0);
    chk("arst_depth", bus.DEPTH_OUT, 0);
    chk("arst_result", bus.RESULT, 0);
    chk("arst_err", bus.ERR, 0);
    #2 RST = 1'b0;
    step();
    push(8'd6);
    push(8'd7);
    do_op("*");
    settle();
    end_tok(vld);
    chk("post_rst_result", bus.RESULT, 42);
    chk("post_rst_vld", vld, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
